// File: rtl/pim_pkg.sv
// Shared constants for the PIM input buffer and result path: geometry and
// input-buffer state encoding.
package pim_pkg;

  localparam int PIM_WORD_W    = 32;
  localparam int PIM_NUM_WORDS = 256;
  localparam int PIM_CNT_W     = $clog2(PIM_NUM_WORDS);

  typedef enum logic [1:0] {
    PIM_IB_IDLE  = 2'd0,
    PIM_IB_FILL  = 2'd1,
    PIM_IB_VALID = 2'd2
  } pim_ib_state_e;

endpackage

// File: rtl/pim_input_buffer_if.sv
// Bus-side write port plus PIM-side valid/ready vector port of the input buffer.
// The master drives writes, clear and ready; the buffer is the slave.
interface pim_input_buffer_if
  import pim_pkg::*;
#(
  parameter int WORD_W    = PIM_WORD_W,
  parameter int NUM_WORDS = PIM_NUM_WORDS,
  parameter int CNT_W     = PIM_CNT_W
);

  logic                        clear;
  logic                        wr_en;
  logic [WORD_W-1:0]           wr_data;
  logic [CNT_W:0]              wr_count;
  logic                        full;
  logic                        overflow;
  logic                        valid;
  logic                        ready;
  logic [NUM_WORDS*WORD_W-1:0] data;

  modport master (
    output clear, wr_en, wr_data, ready,
    input  wr_count, full, overflow, valid, data
  );

  modport slave (
    input  clear, wr_en, wr_data, ready,
    output wr_count, full, overflow, valid, data
  );

endinterface

// File: rtl/pim_ib_ctrl.sv
// Fill controller: IDLE/FILL/VALID state machine, word pointer, sticky overflow
// and the one-hot word-write enable driving the storage slices.
module pim_ib_ctrl
  import pim_pkg::*;
#(
  parameter int NUM_WORDS = PIM_NUM_WORDS,
  parameter int CNT_W     = PIM_CNT_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_wr_en,
  input  logic                 i_ready,
  output logic [CNT_W:0]       o_wr_count,
  output logic                 o_full,
  output logic                 o_overflow,
  output logic                 o_valid,
  output logic [NUM_WORDS-1:0] o_word_we
);

  localparam logic [CNT_W:0] LAST_PTR = (CNT_W+1)'(NUM_WORDS - 1);

  pim_ib_state_e  state;
  logic [CNT_W:0] ptr;
  logic           accept;

  // Clear beats a simultaneous write, and a complete vector refuses writes.
  assign accept = i_wr_en && !i_clear && (state != PIM_IB_VALID);

  // NOTE: default every always_comb output first so no path infers a latch.
  always_comb begin
    o_word_we                   = '0;
    o_word_we[ptr[CNT_W-1:0]] = accept;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= PIM_IB_IDLE;
      ptr        <= '0;
      o_overflow <= 1'b0;
    end else if (i_clear) begin
      state      <= PIM_IB_IDLE;
      ptr        <= '0;
      o_overflow <= 1'b0;
    end else begin
      case (state)
        PIM_IB_IDLE, PIM_IB_FILL: begin
          if (i_wr_en) begin
            ptr   <= ptr + 1'b1;
            state <= (ptr == LAST_PTR) ? PIM_IB_VALID : PIM_IB_FILL;
          end
        end
        PIM_IB_VALID: begin
          if (i_wr_en) o_overflow <= 1'b1;
          if (i_ready) begin
            state <= PIM_IB_IDLE;
            ptr   <= '0;
          end
        end
        default: begin
          state <= PIM_IB_IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign o_wr_count = ptr;
  assign o_valid    = (state == PIM_IB_VALID);
  assign o_full     = (state == PIM_IB_VALID);

endmodule

// File: rtl/pim_input_buffer.sv
// Packs streamed bus words into one wide PIM vector (word 0 in the top slice)
// and offers it to the PIM array over valid/ready.
module pim_input_buffer
  import pim_pkg::*;
#(
  parameter int WORD_W    = PIM_WORD_W,
  parameter int NUM_WORDS = PIM_NUM_WORDS,
  parameter int CNT_W     = PIM_CNT_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  pim_input_buffer_if.slave   bus
);

  logic [NUM_WORDS-1:0] word_we;

  pim_ib_ctrl #(
    .NUM_WORDS (NUM_WORDS),
    .CNT_W     (CNT_W)
  ) u_ctrl (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (bus.clear),
    .i_wr_en    (bus.wr_en),
    .i_ready    (bus.ready),
    .o_wr_count (bus.wr_count),
    .o_full     (bus.full),
    .o_overflow (bus.overflow),
    .o_valid    (bus.valid),
    .o_word_we  (word_we)
  );

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    logic [WORD_W-1:0] word_q;

    // NOTE: storage is reset deliberately so the vector reads as all-zero
    // after reset; clear leaves contents intact.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n)        word_q <= '0;
      else if (word_we[k]) word_q <= bus.wr_data;
    end

    assign bus.data[(NUM_WORDS-k)*WORD_W-1 -: WORD_W] = word_q;
  end

endmodule

// File: tb/tb_pim_input_buffer.sv
// Directed self-checking bench for pim_input_buffer: fill, handshake, overflow,
// clear and mid-fill reset, with hand-computed expected words.
module tb_pim_input_buffer;
  import pim_pkg::*;

  localparam int WORD_W    = PIM_WORD_W;
  localparam int NUM_WORDS = PIM_NUM_WORDS;
  localparam int CNT_W     = PIM_CNT_W;

  logic i_clk;
  logic i_rst_n;

  int n_checks;
  int n_errors;

  pim_input_buffer_if #(
    .WORD_W    (WORD_W),
    .NUM_WORDS (NUM_WORDS),
    .CNT_W     (CNT_W)
  ) bus ();

  pim_input_buffer #(
    .WORD_W    (WORD_W),
    .NUM_WORDS (NUM_WORDS),
    .CNT_W     (CNT_W)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [WORD_W-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  function automatic logic [WORD_W-1:0] word_at(input int k);
    return bus.data[(NUM_WORDS-k)*WORD_W-1 -: WORD_W];
  endfunction

  logic [NUM_WORDS*WORD_W-1:0] snap;
  logic [WORD_W-1:0]           exp_word [NUM_WORDS];

  initial begin
    int hits;
    int bad;
    int stable;

    n_checks    = 0;
    n_errors    = 0;
    i_rst_n     = 1'b0;
    bus.clear   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.ready   = 1'b0;

    // Reset held for two edges, then released.
    tick();
    tick();
    i_rst_n = 1'b1;
    check("rst_data_zero", 64'(|bus.data), 64'd0);
    check("rst_count",     64'(bus.wr_count), 64'd0);
    check("rst_valid",     64'(bus.valid), 64'd0);
    check("rst_overflow",  64'(bus.overflow), 64'd0);
    check("rst_full",      64'(bus.full), 64'd0);
    tick();
    check("idle_count",    64'(bus.wr_count), 64'd0);

    // Fill with value = index on consecutive cycles.
    for (int i = 0; i < NUM_WORDS; i++) begin
      wr(WORD_W'(i));
      if (i == NUM_WORDS - 2) begin
        check("fill_valid_early", 64'(bus.valid), 64'd0);
        check("fill_count_255",   64'(bus.wr_count), 64'd255);
      end
    end
    check("fill_valid",   64'(bus.valid), 64'd1);
    check("fill_full",    64'(bus.full), 64'd1);
    check("fill_count",   64'(bus.wr_count), 64'd256);
    check("fill_word0",   64'(bus.data[8191:8160]), 64'h0);
    check("fill_word255", 64'(bus.data[31:0]), 64'hFF);
    check("fill_word100", 64'(word_at(100)), 64'd100);

    // Hold ready low: vector must not move.
    snap   = bus.data;
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.data !== snap || bus.valid !== 1'b1) stable = 0;
    end
    check("hold_stable", 64'(stable), 64'd1);
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    check("hs_valid_drop", 64'(bus.valid), 64'd0);
    check("hs_count_zero", 64'(bus.wr_count), 64'd0);
    check("hs_data_held",  64'(word_at(255)), 64'hFF);
    wr(32'hDEADBEEF);
    check("post_hs_word0", 64'(bus.data[8191:8160]), 64'hDEADBEEF);
    check("post_hs_word1", 64'(word_at(1)), 64'd1);
    check("post_hs_count", 64'(bus.wr_count), 64'd1);

    // Refill to VALID, then write while handshaking.
    for (int i = 1; i < NUM_WORDS; i++) wr(WORD_W'(i));
    check("refill_valid", 64'(bus.valid), 64'd1);
    bus.wr_en   = 1'b1;
    bus.wr_data = 32'h12345678;
    bus.ready   = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
    bus.ready   = 1'b0;
    check("ovf_valid_drop", 64'(bus.valid), 64'd0);
    check("ovf_set",        64'(bus.overflow), 64'd1);
    check("ovf_count",      64'(bus.wr_count), 64'd0);
    check("ovf_word0",      64'(word_at(0)), 64'hDEADBEEF);
    hits = 0;
    for (int k = 0; k < NUM_WORDS; k++) if (word_at(k) == 32'h12345678) hits++;
    check("ovf_no_word", 64'(hits), 64'd0);

    // Ten writes with ready high (ignored outside VALID), then clear+write.
    bus.ready = 1'b1;
    for (int i = 0; i < 10; i++) wr(WORD_W'(32'h100 + i));
    bus.ready = 1'b0;
    check("pre_clr_count",    64'(bus.wr_count), 64'd10);
    check("ovf_sticky",       64'(bus.overflow), 64'd1);
    bus.clear   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 32'hAAAA5555;
    tick();
    bus.clear   = 1'b0;
    bus.wr_en   = 1'b0;
    check("clr_count",    64'(bus.wr_count), 64'd0);
    check("clr_overflow", 64'(bus.overflow), 64'd0);
    check("clr_valid",    64'(bus.valid), 64'd0);
    check("clr_word0",    64'(word_at(0)), 64'h100);
    check("clr_word9",    64'(word_at(9)), 64'h109);
    check("clr_word10",   64'(word_at(10)), 64'd10);
    wr(32'h77);
    check("clr_idle_word0", 64'(word_at(0)), 64'h77);
    check("clr_idle_word1", 64'(word_at(1)), 64'h101);
    check("clr_idle_count", 64'(bus.wr_count), 64'd1);

    // Reset in the middle of a fill.
    for (int i = 1; i < 100; i++) wr(WORD_W'(32'h200 + i));
    check("mid_count", 64'(bus.wr_count), 64'd100);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    check("mid_rst_data",     64'(|bus.data), 64'd0);
    check("mid_rst_count",    64'(bus.wr_count), 64'd0);
    check("mid_rst_overflow", 64'(bus.overflow), 64'd0);

    for (int i = 0; i < NUM_WORDS; i++) begin
      exp_word[i] = 32'hC0DE0000 | WORD_W'(i);
      wr(exp_word[i]);
    end
    check("final_valid", 64'(bus.valid), 64'd1);
    check("final_count", 64'(bus.wr_count), 64'd256);
    bad = 0;
    for (int k = 0; k < NUM_WORDS; k++) if (word_at(k) !== exp_word[k]) bad++;
    check("final_words_bad", 64'(bad), 64'd0);
    check("final_word0",     64'(bus.data[8191:8160]), 64'hC0DE0000);
    check("final_word255",   64'(bus.data[31:0]), 64'hC0DE00FF);
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    check("final_hs_valid", 64'(bus.valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pim_input_buffer.md
Name: pim_input_buffer

Overview:
- Write-side counterpart of the PIM result path.
- CPU-facing logic streams 32-bit words in one per cycle. The block packs them into a single NUM_WORDS*WORD_W-bit vector (8192 bits by default) and presents it to the PIM array through a valid/ready handshake.
- Sits in pim_wrap between the bus-side register interface and the PIM macro input.
- Packing order is identical to the result path: word 0 occupies the most-significant slice.

Parameters:
- WORD_W, 32, width of one bus word.
- NUM_WORDS, 256, words per PIM vector.
- CNT_W, 8, pointer width; must equal clog2(NUM_WORDS).

Ports:
- i_clk  input  1  clock; all logic is rising-edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_clear  input  1  abort fill. Pointer goes to 0, state to IDLE, overflow clears. Vector contents are kept.
- i_wr_en  input  1  write strobe; one word per cycle.
- i_wr_data  input  WORD_W  word to store.
- o_wr_count  output  CNT_W+1  number of words accepted into the current vector (0..NUM_WORDS).
- o_full  output  1  high while in VALID; writes are refused.
- o_overflow  output  1  sticky; a write was refused.
- o_valid  output  1  vector complete and offered to PIM.
- i_ready  input  1  PIM accepts the vector this cycle.
- o_data  output  NUM_WORDS*WORD_W  packed vector. Word k sits at bits [(NUM_WORDS-k)*WORD_W-1 : (NUM_WORDS-k-1)*WORD_W].

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - state=IDLE, pointer=0, o_wr_count=0, o_full=0, o_overflow=0, o_valid=0.
  - All vector storage is zeroed, so o_data=0.
- States: IDLE (pointer 0), FILL (0 < pointer < NUM_WORDS), VALID (vector complete).
- IDLE:
  - i_wr_en stores word 0 and sets pointer=1.
  - Next state is FILL, or VALID if NUM_WORDS==1.
- FILL:
  - i_wr_en stores the word at the pointer and increments the pointer.
  - When the write hits pointer NUM_WORDS-1, next state is VALID and o_wr_count=NUM_WORDS.
- VALID:
  - o_valid=1 and o_full=1.
  - On i_valid&i_ready at the edge: next state IDLE, pointer=0, o_wr_count=0, o_valid drops the following cycle.
  - o_data holds its value after the handshake until overwritten word by word.
- Write latency: a word written at edge N appears in o_data after edge N, i.e. visible in cycle N+1.
- o_valid rises in the cycle after the final write.
- o_data is stable for the whole time o_valid=1.
- i_ready while not VALID is ignored.
- Write while VALID:
  - The word is dropped, o_overflow is set, and o_data is unchanged.
  - This holds even if i_ready is high in the same cycle; the handshake still completes.
- Simultaneous i_clear and i_wr_en: clear wins and the write is dropped.
- i_clear during VALID: the vector is withdrawn and o_valid=0 next cycle.
- Pointer never wraps. Counting past NUM_WORDS is impossible because writes are refused in VALID.
- o_overflow clears only on reset or i_clear.
- Reset mid-fill or mid-VALID: immediate return to the reset values above at that edge.
- All outputs are registered except o_full and o_valid, which are decoded from the state register (no input-to-output combinational path).

Decomposition:
- Shared package pim_pkg holds:
  - state encoding constants PIM_IB_IDLE=2'd0, PIM_IB_FILL=2'd1, PIM_IB_VALID=2'd2;
  - PIM_WORD_W and PIM_NUM_WORDS, reused with the result path.
- Natural sub-module: pim_ib_ctrl. It holds the FSM, pointer, count, overflow and handshake, and outputs a one-hot word-write enable to a flat storage array in the top.
- Storage is a generate loop over NUM_WORDS slices.

Test Plan:
- Reset with i_rst_n=0 for 2 cycles, then release -> o_data=0, o_wr_count=0, o_valid=0, o_overflow=0.
- Write words 0x00000000..0x000000FF (value=index) on 256 consecutive cycles:
  - o_valid=1 exactly one cycle after the 256th write;
  - o_data[8191:8160]=0x0, o_data[31:0]=0xFF, o_wr_count=256.
- With o_valid=1, hold i_ready=0 for 5 cycles, then pulse it:
  - o_data stable during the hold;
  - o_valid=0 and o_wr_count=0 the next cycle;
  - next write of 0xDEADBEEF lands in o_data[8191:8160].
- In VALID, write 0x12345678 with i_ready=1 in the same cycle -> handshake completes, o_overflow=1, and no word 0x12345678 appears in o_data.
- After 10 writes, assert i_clear together with i_wr_en=1 (data 0xAAAA5555):
  - o_wr_count=0, state IDLE, o_overflow=0;
  - words 0..9 retained, word 10 unchanged.
- Pull i_rst_n low while in FILL at count 100 -> o_data=0, o_wr_count=0 next cycle; a full refill then produces a correct vector.
